// File: rtl/net_rx_packet_buffer_if.sv
// Beat stream bundle (valid/ready plus 64-bit data, byte keep and last).
interface net_rx_packet_buffer_if;
  logic        valid;
  logic        ready;
  logic [63:0] data;
  logic [7:0]  keep;
  logic        last;

  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/net_rx_packet_buffer.sv
// Store-and-forward receive buffer: packets become visible only once fully
// written; packets that overflow the remaining space are dropped whole.
module net_rx_packet_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  net_rx_packet_buffer_if.slave  in_s,
  net_rx_packet_buffer_if.master out_m,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef enum logic {ST_NORMAL = 1'b0, ST_DROP = 1'b1} state_t;

  beat_t            mem [DEPTH];
  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] used;
  logic             full;
  logic             mem_we;
  logic             pkt_inc;
  logic             drop_inc;
  logic             rd_fire;
  beat_t            rd_beat;

  assign in_s.ready = 1'b1;

  // Occupancy from registered pointers only; a same-cycle read does not free space.
  assign used = wr_ptr_q - rd_ptr_q;
  assign full = (used == PTR_W'(DEPTH));

  // Read side: committed region is [rd_ptr, cm_ptr).
  assign rd_beat     = mem[rd_ptr_q[AW-1:0]];
  assign out_m.valid = (rd_ptr_q != cm_ptr_q);
  assign out_m.data  = rd_beat.data;
  assign out_m.keep  = rd_beat.keep;
  assign out_m.last  = rd_beat.last;
  assign rd_fire     = out_m.valid & out_m.ready;

  // Next-state: speculative write, commit on last, rewind and drop on overflow.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_we   = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;

    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (in_s.valid) begin
      case (state_q)
        ST_NORMAL: begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (in_s.last) begin
              cm_ptr_d = wr_ptr_q + PTR_W'(1);
              pkt_inc  = 1'b1;
            end
          end else begin
            wr_ptr_d = cm_ptr_q;
            if (in_s.last) begin
              drop_inc = 1'b1;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
        ST_DROP: begin
          wr_ptr_d = cm_ptr_q;
          if (in_s.last) begin
            drop_inc = 1'b1;
            state_d  = ST_NORMAL;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  // State, pointer and saturating counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_NORMAL;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (pkt_inc && (pkt_count != '1)) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end
      if (drop_inc && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  // Beat storage; entries are written once and never modified afterwards.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= '{data: in_s.data, keep: in_s.keep, last: in_s.last};
    end
  end

endmodule

// File: doc/net_rx_packet_buffer.md
# net_rx_packet_buffer

Store-and-forward receive buffer that sits directly downstream of the simulated network endpoint's `net_in` stream and feeds the NIC receive path. The upstream source cannot be back-pressured, so the block always accepts beats. It releases a packet downstream only after the packet's last beat has been written. Packets that do not fit in the remaining space are dropped whole and counted.

## Interface
- `DEPTH`, 64: buffer capacity in 64-bit beats; power of two, ≥ 4.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: tied to 1 (never back-pressures).
- `in_data` in 64: beat data.
- `in_keep` in 8: byte-valid mask, stored unmodified.
- `in_last` in 1: final beat of packet.
- `out_valid` out 1: committed beat available.
- `out_ready` in 1: downstream accepts.
- `out_data` out 64: stored data at read pointer.
- `out_keep` out 8: stored keep at read pointer.
- `out_last` out 1: stored last at read pointer.
- `pkt_count` out CNT_W: packets committed, saturating.
- `drop_count` out CNT_W: packets dropped, saturating.

## Operation
- Storage: DEPTH entries of {data, keep, last}, 73 bits each.
- Pointers are log2(DEPTH)+1 bits wide, with a wrap bit:
  - `wr_ptr`: speculative write position.
  - `cm_ptr`: commit position, end of the last complete packet.
  - `rd_ptr`: read position.
- Used space is `wr_ptr - rd_ptr`, computed modulo 2^(log2(DEPTH)+1). Full when used == DEPTH. Fullness is evaluated on registered pointers, so a read in the same cycle does not free space for that cycle's write.
- FSM states: NORMAL, DROP.
- NORMAL, beat accepted, not full:
  - Write the beat at `wr_ptr`; `wr_ptr`++.
  - If `in_last`: `cm_ptr` <= `wr_ptr`+1; `pkt_count`++.
- NORMAL, beat accepted while full:
  - Discard the beat; `wr_ptr` <= `cm_ptr` (rewind the partial packet).
  - If `in_last`: `drop_count`++ and stay in NORMAL. Otherwise go to DROP.
- DROP: discard every beat.
  - On `in_last`: `drop_count`++, go to NORMAL.
  - `wr_ptr` stays equal to `cm_ptr`.
- Packets longer than DEPTH beats always overflow and are always dropped.
- Read side:
  - `out_valid` = (`rd_ptr` != `cm_ptr`).
  - `out_*` are driven combinationally from the entry at `rd_ptr`.
  - On `out_valid && out_ready`: `rd_ptr`++.
- Counters saturate at 2^CNT_W − 1 and do not wrap.
- Stored data is never modified.

## Timing
- Reset values:
  - All pointers 0; state NORMAL.
  - `out_valid` 0; `pkt_count` 0; `drop_count` 0; `in_ready` 1.
  - `out_data`, `out_keep`, `out_last` are don't-care while `out_valid` is 0.
- Latency: the first beat of a packet appears on `out_valid` in the cycle after its `last` beat is accepted. Minimum latency is 1 cycle for a single-beat packet.
- Throughput: one beat per cycle in and one beat per cycle out, simultaneously.
- Output handshake: while `out_valid` is 1 and `out_ready` is 0, `out_*` hold steady.
- Simultaneous commit and read: a read of the previously committed data proceeds normally. The new packet becomes visible the next cycle.
- Wrap-around: pointer arithmetic is modulo; the wrap bit distinguishes full from empty.
- Reset mid-packet, in either state: all state clears. The remaining beats of the interrupted packet are written as a new packet and committed at their `last`.

## Test plan
- DEPTH=8. Single 3-beat packet, data 0x11/0x22/0x33, `last` on the third beat, `out_ready`=1:
  - `out_valid` rises the cycle after 0x33 is accepted.
  - Output is 0x11, 0x22, 0x33 with `last` on 0x33.
  - `pkt_count`=1.
- `out_ready`=0. Send 5-beat packet A, then 4-beat packet B:
  - A is committed.
  - B overflows on its 4th beat and `drop_count`=1.
  - Raise `out_ready`: exactly A's 5 beats emerge, then `out_valid` stays 0.
- `out_ready`=0. 10-beat packet: dropped, `drop_count`=1, `pkt_count`=0, `out_valid` never rises. A following 2-beat packet is delivered intact.
- Back-to-back 1-beat packets every cycle for 40 cycles, `out_ready`=1:
  - All 40 emerge in order, with pointers wrapping 5 times.
  - `pkt_count`=40, no drops.
- `out_ready` toggled pseudo-randomly while a 4-beat packet is read: data is held while stalled and no beat is duplicated or lost.
- Assert `reset` during the 2nd beat of a 3-beat packet:
  - After reset, counters are 0 and `out_valid`=0.
  - The remaining beat is delivered as a 1-beat packet.
